// File: rtl/gray_rx_decoder_pkg.sv
// Shared types and Gray-to-binary helper for the Gray count receive path.
package gray_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned GRAY_MAX_W    = 32;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      FIRST = 2'd0,
      HOLD  = 2'd1,
      STEP  = 2'd2,
      BREAK = 2'd3
   } sample_class_e;

   // Zero-extended input decodes identically, so one wide function serves every WIDTH.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_rx_decoder_if.sv
// Sample/result bundle of the Gray receive decoder; parity pins exist only with GRAY_RX_PARITY_EN.
interface gray_rx_decoder_if #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8
);
   logic [WIDTH-1:0]     gray_in;
   logic                 gray_valid;
   logic                 clr_err;
   logic [WIDTH-1:0]     bin_out;
   logic                 bin_valid;
   logic                 locked;
   logic                 seq_err;
   logic [ERR_CNT_W-1:0] err_count;
`ifdef GRAY_RX_PARITY_EN
   logic                 gray_par;
   logic                 par_err;

   modport master (output gray_in, gray_valid, clr_err, gray_par,
                   input  bin_out, bin_valid, locked, seq_err, err_count, par_err);
   modport slave  (input  gray_in, gray_valid, clr_err, gray_par,
                   output bin_out, bin_valid, locked, seq_err, err_count, par_err);
`else
   modport master (output gray_in, gray_valid, clr_err,
                   input  bin_out, bin_valid, locked, seq_err, err_count);
   modport slave  (input  gray_in, gray_valid, clr_err,
                   output bin_out, bin_valid, locked, seq_err, err_count);
`endif
endinterface

// File: rtl/gray_rx_decoder_gray2bin_comb.sv
// Purely combinational Gray-to-binary conversion of a WIDTH-bit word.
module gray2bin_comb
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   logic [GRAY_MAX_W-1:0] wide_bin;

   always_comb begin
      wide_bin = gray2bin(GRAY_MAX_W'(gray_i));
      bin_o    = WIDTH'(wide_bin);
   end

endmodule

// File: rtl/gray_rx_decoder.sv
// Decodes Gray samples, tracks +1 sequence lock and counts sequence breaks.
// Optional parity checking is enabled with GRAY_RX_PARITY_EN.
module gray_rx_decoder
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned LOCK_COUNT = 2,
   parameter int unsigned ERR_CNT_W  = 8
) (
   input logic             G_CLK_TX,
   input logic             rst,
   gray_rx_decoder_if.slave bus
);

   localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

   rx_state_e            state_q, state_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic                 have_prev_q, have_prev_d;
   logic [WIDTH-1:0]     bin_out_q, bin_out_d;
   logic                 bin_valid_q, bin_valid_d;
   logic                 locked_q, locked_d;
   logic                 seq_err_q, seq_err_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic                 par_err_q, par_err_d;

   logic [WIDTH-1:0]     bin_c;
   logic                 accept_c;
   logic                 err_inc_c;
   sample_class_e        cls_c;

   gray2bin_comb #(.WIDTH(WIDTH)) u_gray2bin (
      .gray_i (bus.gray_in),
      .bin_o  (bin_c)
   );

   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      have_prev_d = have_prev_q;
      bin_out_d   = bin_out_q;
      bin_valid_d = 1'b0;
      locked_d    = locked_q;
      seq_err_d   = 1'b0;
      err_count_d = err_count_q;
      par_err_d   = 1'b0;
      err_inc_c   = 1'b0;
      accept_c    = bus.gray_valid;

`ifdef GRAY_RX_PARITY_EN
      // Even parity: gray_par must equal the XOR of the Gray word.
      if (bus.gray_valid && (bus.gray_par != ^bus.gray_in)) begin
         accept_c  = 1'b0;
         par_err_d = 1'b1;
         err_inc_c = 1'b1;
      end
`endif

      if (!have_prev_q)                        cls_c = FIRST;
      else if (bin_c == bin_out_q)             cls_c = HOLD;
      else if (bin_c == bin_out_q + WIDTH'(1)) cls_c = STEP;
      else                                     cls_c = BREAK;

      if (accept_c) begin
         bin_valid_d = 1'b1;
         bin_out_d   = bin_c;
         have_prev_d = 1'b1;
         unique case (state_q)
            UNLOCKED: begin
               unique case (cls_c)
                  FIRST: run_d = '0;
                  STEP: begin
                     if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        run_d    = '0;
                     end else begin
                        run_d = run_q + RUN_W'(1);
                     end
                  end
                  BREAK: run_d = '0;
                  default: ;
               endcase
            end
            LOCKED: begin
               if (cls_c == BREAK) begin
                  seq_err_d = 1'b1;
                  err_inc_c = 1'b1;
                  state_d   = UNLOCKED;
                  locked_d  = 1'b0;
                  run_d     = '0;
               end
            end
            default: ;
         endcase
      end

      // Clear wins over a same-cycle increment.
      if (bus.clr_err)
         err_count_d = '0;
      else if (err_inc_c && (err_count_q != {ERR_CNT_W{1'b1}}))
         err_count_d = err_count_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge G_CLK_TX) begin
      if (!rst) begin
         state_q     <= UNLOCKED;
         run_q       <= '0;
         have_prev_q <= 1'b0;
         bin_out_q   <= '0;
         bin_valid_q <= 1'b0;
         locked_q    <= 1'b0;
         seq_err_q   <= 1'b0;
         err_count_q <= '0;
         par_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         have_prev_q <= have_prev_d;
         bin_out_q   <= bin_out_d;
         bin_valid_q <= bin_valid_d;
         locked_q    <= locked_d;
         seq_err_q   <= seq_err_d;
         err_count_q <= err_count_d;
         par_err_q   <= par_err_d;
      end
   end

   assign bus.bin_out   = bin_out_q;
   assign bus.bin_valid = bin_valid_q;
   assign bus.locked    = locked_q;
   assign bus.seq_err   = seq_err_q;
   assign bus.err_count = err_count_q;
`ifdef GRAY_RX_PARITY_EN
   assign bus.par_err   = par_err_q;
`else
   logic unused_par_c;
   assign unused_par_c = par_err_q;
`endif

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed plus randomized bench for gray_rx_decoder against an arithmetic reference model.
module tb_gray_rx_decoder;

   localparam int W    = 4;
   localparam int LOCK = 2;
   localparam int EW   = 2;
   localparam int MODV = 1 << W;
   localparam int EMAX = (1 << EW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   gray_rx_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

   gray_rx_decoder #(.WIDTH(W), .LOCK_COUNT(LOCK), .ERR_CNT_W(EW)) dut (
      .G_CLK_TX (clk),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Reference model state (plain integers)
   int m_bin = 0, m_prev = 0, m_run = 0, m_err = 0;
   bit m_have = 0, m_locked = 0, m_bv = 0, m_se = 0;

   function automatic int enc(input int b);
      return (b ^ (b >> 1)) % MODV;
   endfunction

   // Decode by finding the count whose Gray code matches.
   function automatic int dec(input int g);
      for (int i = 0; i < MODV; i++)
         if (enc(i) == g) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model(input int g, input bit v, input bit c, input bit r);
      int b;
      m_bv = 0;
      m_se = 0;
      if (!r) begin
         m_bin = 0; m_prev = 0; m_run = 0; m_err = 0;
         m_have = 0; m_locked = 0;
         return;
      end
      if (v) begin
         b = dec(g);
         m_bv = 1;
         m_bin = b;
         if (!m_have) begin
            m_have = 1;
            m_run = 0;
         end else if (b == m_prev) begin
         end else if (b == (m_prev + 1) % MODV) begin
            if (!m_locked) begin
               m_run++;
               if (m_run >= LOCK) begin
                  m_locked = 1;
                  m_run = 0;
               end
            end
         end else begin
            if (m_locked) begin
               m_se = 1;
               if (m_err < EMAX) m_err++;
               m_locked = 0;
            end
            m_run = 0;
         end
         m_prev = b;
      end
      if (c) m_err = 0;
   endtask

   task automatic drive(input int g, input bit v, input bit c, input bit r);
      @(negedge clk);
      bus.gray_in    = W'(g);
      bus.gray_valid = v;
      bus.clr_err    = c;
`ifdef GRAY_RX_PARITY_EN
      bus.gray_par   = ^(W'(g));
`endif
      rst = r;
      @(posedge clk);
      #1;
      model(g, v, c, r);
      chk("bin_out",   32'(bus.bin_out),   32'(m_bin));
      chk("bin_valid", 32'(bus.bin_valid), 32'(m_bv));
      chk("locked",    32'(bus.locked),    32'(m_locked));
      chk("seq_err",   32'(bus.seq_err),   32'(m_se));
      chk("err_count", 32'(bus.err_count), 32'(m_err));
   endtask

   task automatic samp(input int b);
      drive(enc(b), 1'b1, 1'b0, 1'b1);
   endtask

   // Break from current value, then re-lock with two steps.
   task automatic break_relock(input bit c);
      int nb;
      nb = (m_prev + 5) % MODV;
      drive(enc(nb), 1'b1, c, 1'b1);
      samp((nb + 1) % MODV);
      samp((nb + 2) % MODV);
   endtask

   initial begin
      int b, sel;
      bus.gray_in    = '0;
      bus.gray_valid = 1'b0;
      bus.clr_err    = 1'b0;
`ifdef GRAY_RX_PARITY_EN
      bus.gray_par   = 1'b0;
`endif
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b0, 1'b0, 1'b1);

      // Lock acquisition with literal Gray codes
      drive(4'b0000, 1'b1, 1'b0, 1'b1);
      drive(4'b0001, 1'b1, 1'b0, 1'b1);
      drive(4'b0011, 1'b1, 1'b0, 1'b1);
      chk("lock_after_third", 32'(bus.locked), 32'd1);
      drive(4'b0010, 1'b1, 1'b0, 1'b1);

      // Break while locked, then re-lock
      drive(4'b0111, 1'b1, 1'b0, 1'b1);
      chk("break_seq_err", 32'(bus.seq_err), 32'd1);
      drive(4'b0101, 1'b1, 1'b0, 1'b1);
      drive(4'b0100, 1'b1, 1'b0, 1'b1);
      chk("relock", 32'(bus.locked), 32'd1);

      // Walk to the top and wrap to zero
      for (int i = 8; i <= 15; i++) samp(i);
      samp(0);
      chk("wrap_locked", 32'(bus.locked), 32'd1);

      // Gaps and a repeated value
      samp(1);
      drive(enc(2), 1'b0, 1'b0, 1'b1);
      samp(1);
      drive(enc(7), 1'b0, 1'b0, 1'b1);
      samp(2);

      // Saturation, then clear coinciding with a break
      for (int i = 0; i < 5; i++) break_relock(1'b0);
      chk("err_saturated", 32'(bus.err_count), 32'(EMAX));
      drive(enc((m_prev + 5) % MODV), 1'b1, 1'b1, 1'b1);
      chk("clr_with_break", 32'(bus.err_count), 32'd0);
      samp((m_prev + 1) % MODV);
      samp((m_prev + 1) % MODV);

      // Mid-stream reset discards history
      break_relock(1'b0);
      break_relock(1'b0);
      chk("err_before_rst", 32'(bus.err_count), 32'd2);
      drive(enc(3), 1'b1, 1'b0, 1'b0);
      samp(9);
      chk("first_after_rst", 32'(bus.seq_err), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel <= 4)      b = (m_prev + 1) % MODV;
         else if (sel <= 6) b = m_prev;
         else               b = int'($urandom_range(0, MODV - 1));
         drive(enc(b), sel != 9, $urandom_range(0, 19) == 0,
               $urandom_range(0, 99) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
